// File: rtl/dcache_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl_if
// Purpose  : Bundles the MEM-stage request/response signals and the external
//            single-word memory bus used by dcache_ctrl.
// Ports    : MEM stage  - ReqValid, ReqWe, Addr, WData, StallM -> RData, DCacheMiss
//            Memory bus - MemReq, MemWe, MemAddr, MemWData -> MemRData, MemAck
//            master : the cache controller's view (drives MemReq and responses)
//            slave  : the pipeline + memory view (drives requests and MemAck)
// Revision : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if;
  // MEM stage side
  logic        ReqValid;
  logic [3:0]  ReqWe;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        StallM;
  logic [31:0] RData;
  logic        DCacheMiss;
  // External memory bus
  logic        MemReq;
  logic [3:0]  MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  modport master (
    input  ReqValid, ReqWe, Addr, WData, StallM, MemRData, MemAck,
    output RData, DCacheMiss, MemReq, MemWe, MemAddr, MemWData
  );

  modport slave (
    output ReqValid, ReqWe, Addr, WData, StallM, MemRData, MemAck,
    input  RData, DCacheMiss, MemReq, MemWe, MemAddr, MemWData
  );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache
//            controller between the MEM stage and a slow single-word memory.
//            Load hits complete with zero penalty; load misses refill a whole
//            line word by word; every store is written through to memory and
//            merged into the line only when it hits.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - dcache_ctrl_if.master (MEM-stage request + memory bus)
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
  parameter int WORD_LOG = 2,   // log2 words per line
  parameter int SET_LOG  = 3    // log2 number of lines
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.master bus
);

  localparam int c_words  = 1 << WORD_LOG;
  localparam int c_sets   = 1 << SET_LOG;
  localparam int c_idx_lo = WORD_LOG + 2;
  localparam int c_tag_lo = SET_LOG + WORD_LOG + 2;
  localparam int c_tag_w  = 32 - c_tag_lo;

  localparam logic [WORD_LOG-1:0] c_cnt_last = '1;
  localparam logic [WORD_LOG-1:0] c_cnt_one  = WORD_LOG'(1);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_refill = 2'd1;
  localparam logic [1:0] c_write  = 2'd2;
  localparam logic [1:0] c_resume = 2'd3;

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [31:0]         r_data  [c_sets][c_words];
  logic [c_tag_w-1:0]  r_tag   [c_sets];
  logic [c_sets-1:0]   r_valid;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [WORD_LOG-1:0] r_cnt;

  // Request fields captured at dispatch so a flushed (changing) Addr cannot
  // redirect an in-flight refill or write merge.
  logic [SET_LOG-1:0]  r_idx;
  logic [c_tag_w-1:0]  r_fill_tag;
  logic [WORD_LOG-1:0] r_word;
  logic                r_wr_hit;

  // --------------------------------------------------------------------------
  // Address decode and hit detection
  // --------------------------------------------------------------------------
  logic [SET_LOG-1:0]  w_idx;
  logic [WORD_LOG-1:0] w_word;
  logic [c_tag_w-1:0]  w_tag;
  logic                w_hit;
  logic                w_load;
  logic                w_unused_addr;

  assign w_idx         = bus.Addr[c_tag_lo-1:c_idx_lo];
  assign w_word        = bus.Addr[c_idx_lo-1:2];
  assign w_tag         = bus.Addr[31:c_tag_lo];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_load        = (bus.ReqWe == 4'b0000);
  assign w_unused_addr = ^bus.Addr[1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (bus.ReqValid) begin
          if (!w_load) begin
            w_state_nxt = c_write;
          end else if (!w_hit) begin
            w_state_nxt = c_refill;
          end
        end
      end
      c_refill: begin
        if (bus.MemAck && (r_cnt == c_cnt_last)) begin
          w_state_nxt = c_resume;
        end
      end
      c_write: begin
        if (bus.MemAck) begin
          w_state_nxt = c_resume;
        end
      end
      c_resume: begin
        if (!bus.StallM) begin
          w_state_nxt = c_idle;
        end
      end
      default: w_state_nxt = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / strobe logic
  // --------------------------------------------------------------------------
  logic w_miss;
  logic w_start_refill;
  logic w_start_write;
  logic w_fill_ack;
  logic w_fill_last;
  logic w_wr_ack;

  always_comb begin
    w_miss         = 1'b0;
    w_start_refill = 1'b0;
    w_start_write  = 1'b0;
    w_fill_ack     = 1'b0;
    w_wr_ack       = 1'b0;
    case (r_state)
      c_idle: begin
        if (bus.ReqValid) begin
          if (!w_load) begin
            w_start_write = 1'b1;
            w_miss        = 1'b1;
          end else if (!w_hit) begin
            w_start_refill = 1'b1;
            w_miss         = 1'b1;
          end
        end
      end
      c_refill: begin
        w_miss     = 1'b1;
        w_fill_ack = bus.MemAck;
      end
      c_write: begin
        w_miss   = 1'b1;
        w_wr_ack = bus.MemAck;
      end
      default: ;  // RESUME: request complete, MemAck ignored
    endcase
  end

  assign w_fill_last = w_fill_ack && (r_cnt == c_cnt_last);

  // The state is already IDLE under reset, but valid bits are clear, so a
  // held load would otherwise look like a miss; gate the stall off instead.
  assign bus.DCacheMiss = w_miss & ~rst;
  assign bus.RData      = r_data[w_idx][w_word];

  // --------------------------------------------------------------------------
  // Bus request registers, refill counter, valid bits
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.MemReq   <= 1'b0;
      bus.MemWe    <= 4'b0000;
      bus.MemAddr  <= 32'h0000_0000;
      bus.MemWData <= 32'h0000_0000;
      r_cnt        <= '0;
      r_valid      <= '0;
      r_idx        <= '0;
      r_fill_tag   <= '0;
      r_word       <= '0;
      r_wr_hit     <= 1'b0;
    end else begin
      if (w_start_refill) begin
        bus.MemReq       <= 1'b1;
        bus.MemWe        <= 4'b0000;
        bus.MemAddr      <= {bus.Addr[31:c_idx_lo], {(WORD_LOG + 2){1'b0}}};
        r_cnt            <= '0;
        // Invalidate now so a partially refilled line can never hit.
        r_valid[w_idx]   <= 1'b0;
        r_idx            <= w_idx;
        r_fill_tag       <= w_tag;
      end else if (w_start_write) begin
        bus.MemReq   <= 1'b1;
        bus.MemWe    <= bus.ReqWe;
        bus.MemAddr  <= {bus.Addr[31:2], 2'b00};
        bus.MemWData <= bus.WData;
        r_idx        <= w_idx;
        r_word       <= w_word;
        r_wr_hit     <= w_hit;
      end else if (w_fill_ack) begin
        if (r_cnt == c_cnt_last) begin
          bus.MemReq     <= 1'b0;
          r_cnt          <= '0;
          r_valid[r_idx] <= 1'b1;
        end else begin
          // Back-to-back word requests: only the word field moves.
          r_cnt                        <= r_cnt + c_cnt_one;
          bus.MemAddr[c_idx_lo-1:2]    <= r_cnt + c_cnt_one;
        end
      end else if (w_wr_ack) begin
        bus.MemReq <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Data and tag arrays (no reset; qualified by r_valid)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_data[r_idx][r_cnt] <= bus.MemRData;
    end
    if (w_fill_last) begin
      r_tag[r_idx] <= r_fill_tag;
    end
    if (w_wr_ack && r_wr_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.MemWe[b]) begin
          r_data[r_idx][r_word][8*b +: 8] <= bus.MemWData[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Small direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the external data memory bus.
- Serves loads and stores from the MEM stage.
- Drives DCacheMiss to the hazard unit, which stalls the pipeline while a refill or write-through is in progress.
- Talks to a slow memory over a single-word req/ack handshake.

Parameters:
- WORD_LOG, 2, log2 of words per line (4 words, 16 B).
- SET_LOG, 3, log2 of number of lines (8 lines).
- Address fields: [1:0] byte, [WORD_LOG+1:2] word, [SET_LOG+WORD_LOG+1:WORD_LOG+2] index, remainder tag.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ReqValid  in  1  MEM stage holds a load or store; held stable while DCacheMiss=1.
- ReqWe  in  4  byte write enables; 0 = load, nonzero = store.
- Addr  in  32  byte address; low 2 bits ignored for array/bus addressing.
- WData  in  32  store data, byte-lane aligned.
- StallM  in  1  MEM register stalled by the hazard unit.
- RData  out  32  load data, word at Addr from the line array (combinational).
- DCacheMiss  out  1  request not yet completed; pipeline must stall.
- MemReq  out  1  bus request, registered.
- MemWe  out  4  bus byte enables, 0 = read.
- MemAddr  out  32  word-aligned bus address.
- MemWData  out  32  bus write data.
- MemRData  in  32  bus read data, valid with MemAck.
- MemAck  in  1  one-cycle completion pulse for the current MemReq.

Behaviour:
- Hit = valid[index] && tag[index]==Addr tag.
- Reset (async):
  - all valid bits cleared, state=IDLE, refill counter=0.
  - MemReq=0, MemWe=0, MemAddr=0, MemWData=0.
  - DCacheMiss forced 0 while rst=1.
  - Data/tag arrays need no reset.
- IDLE:
  - ReqValid=0: DCacheMiss=0.
  - Load hit: DCacheMiss=0, RData valid in the same cycle, zero penalty.
  - Load miss: DCacheMiss=1 combinationally; next state REFILL, cnt=0, MemReq=1, MemWe=0, MemAddr={tag,index,0,2'b00}.
  - Store (hit or miss): DCacheMiss=1; next state WRITE, MemReq=1, MemWe=ReqWe, MemAddr={Addr[31:2],2'b00}, MemWData=WData.
- REFILL:
  - DCacheMiss=1. MemReq stays 1, address stable until MemAck.
  - On MemAck: word cnt of line[index] <= MemRData.
  - If cnt<last: cnt++, MemAddr advances by 4, MemReq stays 1 with no idle cycle.
  - If cnt==last: MemReq=0, tag/valid written, next state RESUME.
  - valid[index] is cleared on REFILL entry, so a partial line is never a hit.
- WRITE:
  - DCacheMiss=1.
  - On MemAck: MemReq=0; if hit, merge enabled bytes of WData into the line word; next state RESUME.
  - Miss: line untouched (no allocate).
- RESUME:
  - DCacheMiss=0. RData from the array: a refilled load now hits; a write has completed.
  - If StallM=1: remain RESUME, no new bus traffic, RData held.
  - Else: IDLE next cycle, where the next instruction's request is evaluated.
- Bus rules:
  - MemAck in IDLE/RESUME is ignored.
  - At most one outstanding MemReq.
  - MemReq deasserts the cycle after the accepting MemAck.
- Simultaneous events:
  - ReqValid falling during REFILL/WRITE (flush): the current bus transaction finishes and the FSM completes normally (refill still installs the line).
  - rst mid-operation aborts immediately: MemReq=0, the line being refilled stays invalid.
- Arithmetic: cnt is WORD_LOG bits and wraps only at REFILL exit. Address increment touches only the word field.

Test Plan:
- After reset, load 0x104 (memory holds 0x100..0x10C = 0x11,0x22,0x33,0x44, 1-cycle ack) -> DCacheMiss=1 same cycle; bus reads 0x100,0x104,0x108,0x10C in order; RESUME gives RData=0x22, DCacheMiss=0. Then load 0x10C -> DCacheMiss=0 same cycle, RData=0x44, no MemReq.
- Store 0x108 WData=0xDEADBEEF ReqWe=1111 (line present) -> MemWe=1111, MemAddr=0x108, DCacheMiss=1 until ack. Load 0x108 hits 0xDEADBEEF. Store ReqWe=0010 WData=0x0000AB00 -> load returns 0xDEADABEF; bus saw MemWe=0010.
- Store miss 0x2000 WData=0x5 -> one bus write only. Subsequent load 0x2000 misses with a 4-word refill from 0x2000.
- Conflict: load 0x104 then load 0x184 (both index 0) -> second misses and refills 0x180..0x18C. Reload 0x104 misses again.
- rst pulse after 2 of 4 refill acks for 0x104 -> MemReq=0 immediately, DCacheMiss=0. Reload 0x104 misses with a full 4-word refill starting at 0x100.
- Load miss reaching RESUME with StallM=1 for 3 cycles -> DCacheMiss=0 and RData stable for all 3 cycles, no MemReq. IDLE only after StallM=0.
